// File: rtl/pc_fetch_if.sv
// Fetch-side bus of pc_fetch: the instruction-memory request/response
// channel and the decode handoff channel, bundled so the sequencer and
// its neighbours share one definition of the handshake signals.
interface pc_fetch_if;
  // instruction memory request channel
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  // instruction memory response channel
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // decode handoff channel
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // fetch sequencer side
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  // memory / decode side
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer for the multicycle RV32I
// core. One instruction is in flight at a time: request, wait for the word,
// hand it to decode, wait for execute to finish, then step the PC. A
// misaligned next PC parks the sequencer in HALT until reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_fetch_if.master        bus,
  input  logic              ex_done,
  input  logic [31:0]       branc_add,
  input  logic              ex_jump,
  input  logic [31:0]       ex_jump_target,
  output logic [31:0]       retired,
  output logic              misaligned
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] next_pc;
  logic        next_aligned;

  // Candidate next PC: jump beats branch; a zero offset means fall-through.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (ex_jump) begin
      // JALR semantics: bit 0 of the target is always cleared
      next_pc = ex_jump_target & 32'hFFFF_FFFE;
    end else if (branc_add != 32'd0) begin
      next_pc = pc_q + branc_add;
    end
  end

  assign next_aligned = (next_pc[1:0] == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; handshakes arriving in the wrong state are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.inst_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ex_done) state_d = next_aligned ? S_REQ : S_HALT;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Datapath next values: capture the fetched word, step PC and counters.
  always_comb begin
    pc_d         = pc_q;
    inst_d       = inst_q;
    retired_d    = retired_q;
    misaligned_d = misaligned_q;
    case (state_q)
      S_WAIT: begin
        if (bus.imem_rsp_valid) inst_d = bus.imem_rsp_data;
      end
      S_EXEC: begin
        if (ex_done) begin
          retired_d = retired_q + 32'd1;
          if (next_aligned) begin
            pc_d = next_pc;
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      retired_q    <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Moore outputs; the request is masked while reset is held.
  always_comb begin
    bus.imem_req_valid = (state_q == S_REQ) && rst_n;
    bus.imem_req_addr  = pc_q;
    bus.inst_valid     = (state_q == S_HOLD);
    bus.inst           = inst_q;
    bus.inst_pc        = pc_q;
    retired            = retired_q;
    misaligned         = misaligned_q;
  end

`ifndef SYNTHESIS
  // A pending request must not drop or move before it is accepted.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.imem_req_valid && !bus.imem_req_ready) |=>
      (bus.imem_req_valid && $stable(bus.imem_req_addr)));

  // Once flagged, a misaligned target stays flagged until reset.
  a_misaligned_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    misaligned_q |=> misaligned_q);

  // A halted sequencer never requests nor presents an instruction.
  a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HALT) |-> (!bus.imem_req_valid && !bus.inst_valid));
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a driver walks a hand-computed instruction
// sequence while a monitor checks every presented request and instruction
// against scoreboard queues filled by the driver.
`timescale 1ns/1ps
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_done = 1'b0;
  logic [31:0] branc_add = 32'd0;
  logic        ex_jump = 1'b0;
  logic [31:0] ex_jump_target = 32'd0;
  logic [31:0] retired;
  logic        misaligned;

  pc_fetch_if pf ();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (pf),
    .ex_done        (ex_done),
    .branc_add      (branc_add),
    .ex_jump        (ex_jump),
    .ex_jump_target (ex_jump_target),
    .retired        (retired),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } inst_exp_t;

  logic [31:0] exp_addr_q[$];
  inst_exp_t   exp_inst_q[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // instruction memory contents, a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample after inputs settle, compare against queue heads.
  initial begin
    inst_exp_t h;
    forever begin
      @(negedge clk);
      #1;
      if (pf.imem_req_valid) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: got request addr %h, expected no request", pf.imem_req_addr);
        end else begin
          chk("req_addr", pf.imem_req_addr, exp_addr_q[0]);
          if (pf.imem_req_ready) begin
            void'(exp_addr_q.pop_front());
            acc_cyc.push_back(cyc);
            $display("req  accepted addr=%h cycle=%0d", pf.imem_req_addr, cyc);
          end
        end
      end
      if (pf.inst_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_inst: got inst %h pc %h, expected none", pf.inst, pf.inst_pc);
        end else begin
          h = exp_inst_q[0];
          chk("inst", pf.inst, h.word);
          chk("inst_pc", pf.inst_pc, h.pc);
          if (pf.inst_ready) begin
            void'(exp_inst_q.pop_front());
            $display("inst accepted pc=%h inst=%h", pf.inst_pc, pf.inst);
          end
        end
      end
    end
  end

  // bounded wait for request (which=0) or instruction (which=1) valid
  task automatic wait_sig(input int which, input string name);
    int n;
    n = 0;
    while (!((which == 0) ? pf.imem_req_valid : pf.inst_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: got 0 for 20 cycles, expected 1", name);
    end
  endtask

  // One full instruction starting from a pending request at cur.
  task automatic run_instr(input logic [31:0] cur, input logic [31:0] br,
                           input logic jmp, input logic [31:0] tgt,
                           input logic [31:0] nxt, input bit halt,
                           input int req_stall, input int rdy_stall, input bit stray);
    logic [31:0] acc_addr;
    exp_inst_q.push_back('{word: mem_word(cur), pc: cur});
    wait_sig(0, "req_valid");
    pf.imem_req_ready = 1'b0;
    repeat (req_stall) @(negedge clk);
    acc_addr = pf.imem_req_addr;
    pf.imem_req_ready = 1'b1;
    @(negedge clk);
    pf.imem_req_ready = 1'b0;
    pf.imem_rsp_valid = 1'b1;
    pf.imem_rsp_data  = mem_word(acc_addr);
    @(negedge clk);
    pf.imem_rsp_valid = 1'b0;
    pf.imem_rsp_data  = 32'd0;
    wait_sig(1, "inst_valid");
    ex_done = stray;
    repeat (rdy_stall) @(negedge clk);
    ex_done = 1'b0;
    pf.inst_ready = 1'b1;
    @(negedge clk);
    pf.inst_ready = 1'b0;
    ex_done = 1'b1;
    branc_add = br;
    ex_jump = jmp;
    ex_jump_target = tgt;
    if (!halt) exp_addr_q.push_back(nxt);
    @(negedge clk);
    ex_done = 1'b0;
    branc_add = 32'd0;
    ex_jump = 1'b0;
    ex_jump_target = 32'd0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", {31'd0, pf.imem_req_valid}, 32'd0);
    chk("rst_req_addr", pf.imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, pf.inst_valid}, 32'd0);
    chk("rst_inst", pf.inst, 32'd0);
    chk("rst_inst_pc", pf.inst_pc, 32'h0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
  endtask

  // Driver.
  initial begin
    pf.imem_req_ready = 1'b0;
    pf.imem_rsp_valid = 1'b0;
    pf.imem_rsp_data  = 32'd0;
    pf.inst_ready     = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();

    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    #2;
    chk("first_req_valid", {31'd0, pf.imem_req_valid}, 32'd1);
    @(negedge clk);

    // sequential fall-through
    run_instr(32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h0000_0004, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_0004, 32'h0, 1'b0, 32'h0, 32'h0000_0008, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_0008, 32'h0, 1'b0, 32'h0, 32'h0000_000C, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_000C, 32'h0, 1'b0, 32'h0, 32'h0000_0010, 1'b0, 0, 0, 1'b0);
    chk("retired_after_4", retired, 32'd4);
    // taken branches, backward then forward from 0x10
    run_instr(32'h0000_0010, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0000_0008, 1'b0, 0, 0, 1'b0);
    if (acc_cyc.size() < 5) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_count: got %0d accepts, expected 5", acc_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++)
        chk("cycles_per_instr", acc_cyc[i+1] - acc_cyc[i], 32'd4);
    end
    run_instr(32'h0000_0008, 32'h0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0, 32'h0000_0030, 1'b0, 0, 0, 1'b0);
    // jump with odd target, then jump priority over branch offset
    run_instr(32'h0000_0030, 32'h0, 1'b1, 32'h0000_0041, 32'h0000_0040, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_0040, 32'h0000_0008, 1'b1, 32'h0000_0101, 32'h0000_0100, 1'b0, 0, 0, 1'b0);
    // backpressure on both channels with a stray ex_done in HOLD
    run_instr(32'h0000_0100, 32'h0, 1'b0, 32'h0, 32'h0000_0104, 1'b0, 3, 2, 1'b1);
    chk("retired_after_stall", retired, 32'd10);
    // wrap past the top of the address space
    run_instr(32'h0000_0104, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 0, 0, 1'b0);
    run_instr(32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 0, 0, 1'b0);
    run_instr(32'h0000_0000, 32'h0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b0, 0, 0, 1'b0);
    // misaligned branch target halts fetch
    run_instr(32'h0000_0020, 32'h0000_0002, 1'b0, 32'h0, 32'h0, 1'b1, 0, 0, 1'b0);
    ex_done = 1'b1;
    pf.imem_rsp_valid = 1'b1;
    pf.inst_ready = 1'b1;
    repeat (4) @(negedge clk);
    ex_done = 1'b0;
    pf.imem_rsp_valid = 1'b0;
    pf.inst_ready = 1'b0;
    chk("halt_misaligned", {31'd0, misaligned}, 32'd1);
    chk("halt_req_valid", {31'd0, pf.imem_req_valid}, 32'd0);
    chk("halt_inst_valid", {31'd0, pf.inst_valid}, 32'd0);
    chk("halt_pc", pf.imem_req_addr, 32'h0000_0020);
    chk("halt_retired", retired, 32'd14);

    // reset out of HALT
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    pf.imem_req_ready = 1'b1;
    @(negedge clk);
    pf.imem_req_ready = 1'b0;
    // reset while the response is still outstanding
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwait_req_valid", {31'd0, pf.imem_req_valid}, 32'd0);
    chk("midwait_retired", retired, 32'd0);
    exp_addr_q.push_back(32'h0);
    rst_n = 1'b1;
    pf.imem_rsp_valid = 1'b1;
    pf.imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    pf.imem_rsp_valid = 1'b0;
    pf.imem_rsp_data  = 32'd0;
    chk("late_rsp_inst", pf.inst, 32'd0);
    chk("late_rsp_req_valid", {31'd0, pf.imem_req_valid}, 32'd1);
    chk("late_rsp_inst_valid", {31'd0, pf.inst_valid}, 32'd0);
    run_instr(32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h0000_0004, 1'b0, 0, 0, 1'b0);
    chk("retired_after_reset", retired, 32'd1);
    chk("inst_queue_drained", exp_inst_q.size(), 32'd0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter and instruction fetch sequencer for the multicycle RV32I core. It sits directly downstream of the branch-condition unit: it consumes that unit's branch offset (zero when the branch is not taken) plus jump information from execute, computes the next PC, fetches the next instruction from instruction memory over a valid/ready handshake, and presents it to decode. It also counts retired instructions and halts fetch on a misaligned target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address, always equals current PC.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  instruction word returned.
- imem_rsp_data  input  32  returned instruction word.
- inst_valid  output  1  fetched instruction available to decode.
- inst  output  32  fetched instruction word.
- inst_pc  output  32  PC of `inst`.
- inst_ready  input  1  decode accepts instruction.
- ex_done  input  1  current instruction finished execute; next-PC inputs valid this cycle.
- branc_add  input  32  branch offset from the branch-condition unit; 0 means fall-through.
- ex_jump  input  1  current instruction is JAL/JALR.
- ex_jump_target  input  32  absolute jump target.
- retired  output  32  count of ex_done events since reset.
- misaligned  output  1  sticky; next PC had bits[1:0] != 0, fetch halted.

## Operation
- FSM states: REQ, WAIT, HOLD, EXEC, HALT. All outputs are driven from registers/state (Moore).
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_valid && imem_req_ready → WAIT. imem_rsp_valid ignored in REQ.
- WAIT: on imem_rsp_valid, inst <= imem_rsp_data → HOLD.
- HOLD: inst_valid=1, inst_pc=pc. On inst_ready → EXEC. inst held stable while stalled.
- EXEC: wait for ex_done. On ex_done: retired <= retired+1; compute next:
  - ex_jump=1 → {ex_jump_target[31:1],1'b0} (JALR LSB clear), takes priority over branc_add.
  - else branc_add != 0 → pc + branc_add, modulo 2^32 (wrap, no overflow flag).
  - else pc + 4, modulo 2^32.
  - next[1:0]==0 → pc <= next, go REQ. Otherwise pc unchanged, misaligned <= 1, go HALT.
- HALT: no requests, inst_valid=0; ex_done, rsp ignored; exit only by reset.
- ex_done outside EXEC, inst_ready outside HOLD, imem_rsp_valid outside WAIT: ignored, no state change.
- Taken branch with offset 0 is indistinguishable from not-taken and advances to pc+4 (known limitation of the offset encoding).
- retired wraps 32'hFFFF_FFFF → 0.

## Timing
- Reset (rst_n=0, asynchronous): state=REQ, pc=RESET_PC, inst=0, retired=0, misaligned=0. Outputs while in reset: imem_req_valid=0 (gated by rst_n), imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, retired=0, misaligned=0.
- First request asserted in the first cycle after rst_n deasserts.
- Best case per instruction (ready same cycle, response next cycle, inst_ready and ex_done immediate): 4 cycles, REQ→WAIT→HOLD→EXEC→REQ.
- imem_req_valid, once asserted, stays high with stable address until accepted.
- Memory must respond at least one cycle after acceptance; a response in the accept cycle is lost.
- pc, retired, misaligned update on the ex_done edge; new imem_req_addr visible the cycle after.
- Reset mid-fetch: pending memory response after reset falls in REQ and is discarded.

## Test plan
- Reset/sequential: RESET_PC=0, memory ready always, 1-cycle latency, branc_add=0 → addresses 0,4,8,C; retired=4 after 4 ex_done; 4 cycles per instruction.
- Taken branch: pc=0x10, branc_add=0xFFFF_FFF8 → next request 0x08; branc_add=0x20 → 0x30.
- Jump priority: pc=0x40, ex_jump=1, ex_jump_target=0x101, branc_add=0x8 → next request 0x100.
- Backpressure: imem_req_ready low 3 cycles, inst_ready low 2 cycles → address and inst stable throughout, no extra retired counts; stray ex_done in HOLD ignored.
- Misaligned/wrap: pc=0xFFFF_FFFC, branc_add=0 → next 0x0; branc_add=0x2 from pc=0x20 → misaligned=1, imem_req_valid stays 0, pc stays 0x20 until reset.
- Reset mid-WAIT: drop rst_n while waiting, return response after release → response ignored, request reissued at RESET_PC, retired=0.
